three_ones_framer_tx: RTL
=========================

# three_ones_framer_tx

Serial framing transmitter: the transmit end of the link whose receiver detects three consecutive ones on a single-bit line. It accepts a parallel word over a valid/ready handshake and emits a frame: marker `1,1,1`, separator `0`, then the payload MSB-first. Bit-stuffing inserts a `0` after every two consecutive payload ones, so `111` appears on the line only as the frame marker. It sits between the parallel source and the serial line that feeds the three-ones detector.

## Interface
- DATA_W, 8, payload width in bits (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- data_in  in  DATA_W  payload word, sampled only on acceptance
- data_valid  in  1  source has a word
- data_ready  out  1  combinational; high iff FSM in IDLE
- a_out  out  1  registered serial line bit
- frame_active  out  1  registered; high for every cycle a frame bit (marker/sep/data/stuff/parity) is on a_out
- stuff_bit  out  1  registered; high in cycles where a_out is an inserted stuff 0

## Operation
- States: IDLE, MARK, SEP, DATA, STUFF, PAR (PAR only with PARITY_EN).
- IDLE: a_out=0, frame_active=0. On data_valid&&data_ready: latch data_in into shift register, bit counter = DATA_W, run counter = 0, go MARK.
- MARK: a_out=1 for exactly 3 cycles (2-bit mark counter), then SEP.
- SEP: a_out=0 for 1 cycle, run counter cleared, then DATA.
- DATA: a_out = shift-register MSB, shift left, decrement bit counter. Run counter increments on 1, clears on 0.
- After the bit that makes the run counter 2: next state STUFF, regardless of remaining bits.
- STUFF: a_out=0, stuff_bit=1, run counter cleared. Next state is DATA if bits remain, PAR if no bits remain and PARITY_EN, else IDLE.
- From DATA, when the last bit is sent and no stuff is pending: PAR (PARITY_EN) or IDLE.
- Stuffing applies to the final data bit and the parity bit: a trailing `11` is always followed by a stuff 0.
- Data is captured at acceptance. data_in and data_valid are ignored outside IDLE.
- Frame length = 4 + DATA_W + number of stuffs (+1 with PARITY_EN).

## Timing
- Reset (rst=0): a_out=0, frame_active=0, stuff_bit=0, state IDLE, all counters 0, shift register 0. The effect is immediate (asynchronous).
- Handshakes while rst=0 are ignored. data_ready reads 1 during reset because state is IDLE.
- Latency: word accepted at edge N → first marker bit on a_out from edge N to N+1 (visible the cycle after acceptance).
- data_ready drops the cycle after acceptance. It returns high the cycle after the last frame bit, with a_out=0 that cycle.
- Inter-frame gap: at least 1 IDLE cycle of a_out=0 between frames. A valid held high gets a new frame every frame_length+1 cycles.
- Reset mid-frame: the partial frame is abandoned, a_out=0 at once, and no word is retained. Resume is in IDLE after rst rises.
- Simultaneous last data bit completing a `11` run: STUFF takes priority over PAR/IDLE.

## Configuration
- PARITY_EN defined: after the data (and any pending stuff), PAR emits one even-parity bit, ^data. The parity bit counts in the run counter and may itself trigger a stuff.
- PARITY_EN undefined: PAR state absent; the frame ends after the last data bit or its stuff.

## Test plan
- Reset/idle: rst=0 mid-stream, then release with data_valid=0 → a_out=0, frame_active=0, stuff_bit=0, data_ready=1 indefinitely.
- data_in=8'h00, no PARITY_EN → a_out `1110_00000000`, 12 frame cycles, zero stuff_bit pulses, data_ready high on cycle 13.
- data_in=8'hFF, no PARITY_EN → `1110` then `11 0 11 0 11 0 11 0`, 16 frame cycles, stuff_bit high on frame cycles 7,10,13,16. A line detector must fire exactly once (marker only).
- data_in=8'hB6, PARITY_EN → `1110` + `1011 0 011 0 0` + parity `1`, 15 frame cycles, 2 stuffs.
- Back-to-back: data_valid held 1 with words 8'hFF then 8'h00 → exactly 1 IDLE zero cycle between frames. The second word is taken from data_in at its own acceptance edge.
- Reset asserted during DATA of 8'hFF → a_out=0 asynchronously. After release, the next accepted word starts with a fresh `1110` marker and no residual bits.

Source files
------------

// File: rtl/three_ones_framer_tx.sv
// rtl/three_ones_framer_tx.sv - marker/separator/bit-stuffed serial framer; optional parity bit via PARITY_EN
module three_ones_framer_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              a_out,
  output logic              frame_active,
  output logic              stuff_bit
);

  localparam int CW = $clog2(DATA_W + 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, MARK, SEP, DATA, STUFF, PAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, MARK, SEP, DATA, STUFF} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [1:0]        run_cnt;
  logic [1:0]        mark_cnt;
`ifdef PARITY_EN
  logic              par_bit;
  logic              par_done;
`endif

  logic msb;
  assign msb        = shreg[DATA_W-1];
  assign data_ready = (state == IDLE);

  // Outputs are registered alongside the state, so each state describes the bit currently on a_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      run_cnt      <= '0;
      mark_cnt     <= '0;
      a_out        <= 1'b0;
      frame_active <= 1'b0;
      stuff_bit    <= 1'b0;
`ifdef PARITY_EN
      par_bit      <= 1'b0;
      par_done     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          a_out        <= 1'b0;
          frame_active <= 1'b0;
          stuff_bit    <= 1'b0;
          if (data_valid) begin
            shreg        <= data_in;
            bit_cnt      <= CW'(DATA_W);
            run_cnt      <= '0;
            mark_cnt     <= '0;
            state        <= MARK;
            a_out        <= 1'b1;
            frame_active <= 1'b1;
`ifdef PARITY_EN
            par_bit      <= ^data_in;
            par_done     <= 1'b0;
`endif
          end
        end
        MARK: begin
          if (mark_cnt == 2'd2) begin
            mark_cnt <= '0;
            run_cnt  <= '0;
            a_out    <= 1'b0;
            state    <= SEP;
          end else begin
            mark_cnt <= mark_cnt + 2'd1;
            a_out    <= 1'b1;
          end
        end
        SEP, DATA, STUFF: begin
          stuff_bit <= 1'b0;
          // A completed run of two ones wins over every other exit, including the last data bit.
          if (state == DATA && run_cnt == 2'd2) begin
            state     <= STUFF;
            a_out     <= 1'b0;
            stuff_bit <= 1'b1;
            run_cnt   <= '0;
          end else if (bit_cnt != '0) begin
            state   <= DATA;
            a_out   <= msb;
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - CW'(1);
            run_cnt <= msb ? run_cnt + 2'd1 : 2'd0;
          end else begin
`ifdef PARITY_EN
            if (!par_done) begin
              state    <= PAR;
              a_out    <= par_bit;
              par_done <= 1'b1;
              run_cnt  <= par_bit ? run_cnt + 2'd1 : 2'd0;
            end else begin
              state        <= IDLE;
              a_out        <= 1'b0;
              frame_active <= 1'b0;
            end
`else
            state        <= IDLE;
            a_out        <= 1'b0;
            frame_active <= 1'b0;
`endif
          end
        end
`ifdef PARITY_EN
        PAR: begin
          if (run_cnt == 2'd2) begin
            state     <= STUFF;
            a_out     <= 1'b0;
            stuff_bit <= 1'b1;
            run_cnt   <= '0;
          end else begin
            state        <= IDLE;
            a_out        <= 1'b0;
            frame_active <= 1'b0;
          end
        end
`endif
        default: begin
          state        <= IDLE;
          a_out        <= 1'b0;
          frame_active <= 1'b0;
          stuff_bit    <= 1'b0;
        end
      endcase
    end
  end

endmodule
